latch_q_monitor: RTL and testbench
==================================

Name: latch_q_monitor

Overview:
- Downstream consumer of the level-sensitive clearable storage latch output (q).
- Brings the asynchronous latch output into the system clock domain and glitch-filters it.
- Emits one-cycle rise/fall event pulses and keeps a saturating count of rising events.
- Sits between the latch bank and the register/status logic that reads latched events.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count; legal values >= 2.
- FILTER_CYCLES, 4, consecutive cycles a new synced value must persist before it is accepted; legal values >= 1.
- CNT_W, 8, event counter width; legal values >= 1.
- TS_W, 16, timestamp width; used only with LATCH_MON_TS_EN.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear_n  in  1  asynchronous, active-low reset; forces all state to reset values immediately.
- latch_q  in  1  latch output; asynchronous to clock.
- cnt_clr  in  1  synchronous clear of event_cnt and cnt_sat.
- level  out  1  filtered, synchronised copy of latch_q.
- rise  out  1  one-cycle pulse on accepted 0->1 of level.
- fall  out  1  one-cycle pulse on accepted 1->0 of level.
- event_cnt  out  CNT_W  count of rise pulses, saturating.
- cnt_sat  out  1  high while event_cnt is all ones.
- rise_ts  out  TS_W  timestamp of the last rise; present only with LATCH_MON_TS_EN.

Behaviour:
- Reset (clear_n low): sync chain, filter counter, level, rise, fall, event_cnt, cnt_sat and rise_ts are all 0.
- Synchroniser: latch_q shifts through SYNC_STAGES flops; s is the last stage.
- Filter, evaluated each edge:
  - If s == level: filter counter <= 0.
  - Else if counter == FILTER_CYCLES-1: level <= s and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Counter width is clog2(FILTER_CYCLES), minimum 1.
- Latency: latch_q changes and is first sampled at edge k. level changes at edge k+SYNC_STAGES+FILTER_CYCLES-1. With defaults, that is edge k+5.
- Rejection: a change on s lasting fewer than FILTER_CYCLES cycles never reaches level and produces no pulse.
- rise and fall:
  - Both are registered and assert at the same edge that level toggles.
  - Each is high for exactly one cycle.
  - They are never both high.
  - Back-to-back toggles are separated by at least FILTER_CYCLES cycles.
- event_cnt:
  - Increments by 1 on the edge where rise is registered.
  - Holds at 2^CNT_W-1 once reached; cnt_sat = (event_cnt == all ones).
- cnt_clr:
  - Next edge, event_cnt <= 0 and cnt_sat <= 0.
  - If a rise is registered on the same edge, event_cnt <= 1, so no event is lost.
- Reset mid-operation: asynchronous clear of all state. After release, if latch_q is still 1, level re-rises after the full latency. That produces a rise pulse, which is counted.
- The latch clear path has no special handling. A latch clear appears as a normal 1->0 on latch_q and yields fall after the latency.

Optional Feature:
- Macro: LATCH_MON_TS_EN.
- Defined:
  - A free-running TS_W counter resets to 0, increments every cycle and wraps at 2^TS_W-1 -> 0.
  - On each edge that registers rise, rise_ts <= current counter value.
  - rise_ts holds until the next rise or reset.
  - cnt_clr does not affect rise_ts.
- Undefined: no timestamp counter, no rise_ts port; TS_W is unused.

Decomposition:
- Shared package latch_mon_pkg holds:
  - Default constants: SYNC_STAGES_DEF=2, FILTER_CYCLES_DEF=4, CNT_W_DEF=8, TS_W_DEF=16.
  - A function computing the filter counter width.
- One sub-module, latch_mon_sync: the parameterised SYNC_STAGES flop chain with async active-low reset. It is instantiated once; the filter, pulse and count logic stays in the top.

Test Plan:
- Reset then clean step: clear_n low 3 cycles, release, latch_q 0->1 before edge 10.
  - level=1 after edge 15.
  - rise high during the cycle following edge 15 only.
  - event_cnt=1.
- Glitch rejection: latch_q high for 2 cycles, then low, with defaults -> level stays 0, no rise, event_cnt unchanged.
- Falling step: from level=1, drive latch_q low -> fall pulse 5 edges later; rise stays 0; event_cnt unchanged.
- Saturation: CNT_W=3, 9 clean high/low cycles each 8 cycles long.
  - event_cnt reaches 7 on rise 7, then holds.
  - cnt_sat=1.
  - cnt_clr pulse -> event_cnt=0, cnt_sat=0.
- Simultaneous clear and rise: assert cnt_clr in the cycle a rise is registered -> event_cnt=1 next edge.
- Mid-operation reset with LATCH_MON_TS_EN:
  - Latch held high, clear_n pulsed low at cycle 20 -> all outputs 0 immediately.
  - rise recurs 5 edges after release.
  - rise_ts equals the timestamp counter value (cycles since release) at that edge.

Source files
------------

// File: rtl/latch_mon_pkg.sv
// Shared constants and helpers for the latch_q monitor slice.
// Optional build macro: LATCH_MON_TS_EN (rise timestamp capture).
package latch_mon_pkg;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 8;
  localparam int TS_W_DEF          = 16;

  // Width of the glitch-filter persistence counter; never narrower than one bit.
  function automatic int filt_cnt_w(input int filter_cycles);
    int w;
    w = $clog2(filter_cycles);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/latch_mon_sync.sv
// Multi-flop synchroniser bringing the asynchronous latch output into the
// clock domain. s is the last stage of the chain.
module latch_mon_sync
  import latch_mon_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic clear_n,
  input  logic d,
  output logic s
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Chain register, cleared asynchronously.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      chain_q <= {STAGES{1'b0}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign s = chain_q[STAGES-1];

endmodule

// File: rtl/latch_q_monitor.sv
// Consumer of the clearable storage latch output: synchronises and
// glitch-filters latch_q, emits rise/fall pulses and counts rises.
// Optional build macro: LATCH_MON_TS_EN adds a free-running timestamp and
// the rise_ts output capturing it on every rise.
module latch_q_monitor
  import latch_mon_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int TS_W          = TS_W_DEF
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             latch_q,
  input  logic             cnt_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] event_cnt,
  output logic             cnt_sat
`ifdef LATCH_MON_TS_EN
  ,
  output logic [TS_W-1:0]  rise_ts
`endif
);

  localparam int               FW        = filt_cnt_w(FILTER_CYCLES);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             s_sync;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  latch_mon_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .clear_n (clear_n),
    .d       (latch_q),
    .s       (s_sync)
  );

  // Filter, edge pulses and saturating rise counter next-state.
  always_comb begin
    fcnt_d  = fcnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;

    // A new synced value must persist FILTER_CYCLES cycles before it is taken.
    if (s_sync == level_q) begin
      fcnt_d = {FW{1'b0}};
    end else if (fcnt_q == FILT_LAST) begin
      level_d = s_sync;
      fcnt_d  = {FW{1'b0}};
      rise_d  = s_sync;
      fall_d  = ~s_sync;
    end else begin
      fcnt_d = fcnt_q + FW'(1);
    end

    // A clear coinciding with a rise keeps that rise so no event is lost.
    if (cnt_clr) begin
      if (rise_d) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = {CNT_W{1'b0}};
      end
    end else if (rise_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    sat_d = (cnt_d == CNT_MAX);
  end

  // Filter and event state registers, cleared asynchronously.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      fcnt_q  <= {FW{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      sat_q   <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign event_cnt = cnt_q;
  assign cnt_sat   = sat_q;

`ifdef LATCH_MON_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] rise_ts_q, rise_ts_d;

  // Free-running timestamp; rise_ts captures it on each registered rise.
  always_comb begin
    ts_d = ts_q + TS_W'(1);
    if (rise_d) begin
      rise_ts_d = ts_q;
    end else begin
      rise_ts_d = rise_ts_q;
    end
  end

  // Timestamp registers, cleared asynchronously and untouched by cnt_clr.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      ts_q      <= {TS_W{1'b0}};
      rise_ts_q <= {TS_W{1'b0}};
    end else begin
      ts_q      <= ts_d;
      rise_ts_q <= rise_ts_d;
    end
  end

  assign rise_ts = rise_ts_q;
`endif

endmodule

// File: tb/tb_latch_q_monitor.sv
// Directed bench for latch_q_monitor (SYNC_STAGES=2, FILTER_CYCLES=4, CNT_W=3).
// Expected output snapshots are queued per edge when stimulus is driven and
// checked at the falling clock edge after that rising edge.
module tb_latch_q_monitor;

  typedef struct {
    int          at;
    string       tag;
    logic        lvl;
    logic        r;
    logic        f;
    logic [2:0]  cnt;
    logic        sat;
    logic        chk_ts;
    logic [15:0] ts;
  } exp_t;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       latch_q;
  logic       cnt_clr;
  logic       level;
  logic       rise;
  logic       fall;
  logic [2:0] event_cnt;
  logic       cnt_sat;
`ifdef LATCH_MON_TS_EN
  logic [15:0] rise_ts;
`endif

  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clock = ~clock;

  // Rising-edge number; edge n is the n-th rising edge since time 0.
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  latch_q_monitor #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (4),
    .CNT_W         (3),
    .TS_W          (16)
  ) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .latch_q   (latch_q),
    .cnt_clr   (cnt_clr),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .event_cnt (event_cnt),
    .cnt_sat   (cnt_sat)
`ifdef LATCH_MON_TS_EN
    ,
    .rise_ts   (rise_ts)
`endif
  );

  task automatic wait_to(input int e);
    while (edge_cnt < e) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int at, input string tag, input logic lvl, input logic r,
                      input logic f, input logic [2:0] cnt, input logic sat,
                      input logic chk_ts, input logic [15:0] ts);
    exp_t e;
    e.at = at; e.tag = tag; e.lvl = lvl; e.r = r; e.f = f;
    e.cnt = cnt; e.sat = sat; e.chk_ts = chk_ts; e.ts = ts;
    sb.push_back(e);
  endtask

  // latch_q driven to v just after edge e: level toggles at edge e+6.
  task automatic expect_toggle(input int e, input string tag, input logic v,
                               input logic [2:0] cnt_b, input logic sat_b,
                               input logic [2:0] cnt_a, input logic sat_a);
    push(e + 5, {tag, "_pre"}, ~v, 1'b0, 1'b0, cnt_b, sat_b, 1'b0, 16'd0);
    push(e + 6, tag, v, v, ~v, cnt_a, sat_a, 1'b0, 16'd0);
    push(e + 7, {tag, "_post"}, v, 1'b0, 1'b0, cnt_a, sat_a, 1'b0, 16'd0);
  endtask

  initial begin
    clear_n = 1'b0;
    latch_q = 1'b0;
    cnt_clr = 1'b0;

    fork
      forever begin
        @(negedge clock);
        while (sb.size() > 0 && sb[0].at < edge_cnt) begin
          cur = sb.pop_front();
          total++;
          bad++;
          $error("FAIL %s: check for edge %0d missed (now edge %0d)", cur.tag, cur.at, edge_cnt);
        end
        if (sb.size() > 0 && sb[0].at == edge_cnt) begin
          cur = sb.pop_front();
          total++;
          assert ({level, rise, fall, event_cnt, cnt_sat} === {cur.lvl, cur.r, cur.f, cur.cnt, cur.sat})
          else begin
            bad++;
            $error("FAIL %s edge=%0d got lvl/rise/fall/cnt/sat=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                   cur.tag, edge_cnt, level, rise, fall, event_cnt, cnt_sat,
                   cur.lvl, cur.r, cur.f, cur.cnt, cur.sat);
          end
`ifdef LATCH_MON_TS_EN
          if (cur.chk_ts) begin
            total++;
            assert (rise_ts === cur.ts)
            else begin
              bad++;
              $error("FAIL %s_ts edge=%0d got rise_ts=%0d expected %0d", cur.tag, edge_cnt, rise_ts, cur.ts);
            end
          end
`endif
        end
      end
    join_none

    // Reset state while clear_n is held low.
    push(2, "reset", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'd0);
    wait_to(3);
    clear_n = 1'b1;

    // Clean rising step sampled at edge 10 -> level and rise at edge 15.
    wait_to(9);
    latch_q = 1'b1;
    expect_toggle(9, "step_rise", 1'b1, 3'd0, 1'b0, 3'd1, 1'b0);

    // Falling step: fall pulse, counter unchanged.
    wait_to(20);
    latch_q = 1'b0;
    expect_toggle(20, "step_fall", 1'b0, 3'd1, 1'b0, 3'd1, 1'b0);

    // Two-cycle glitch must never reach level.
    wait_to(30);
    latch_q = 1'b1;
    for (int e = 33; e <= 40; e++) begin
      push(e, "glitch", 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 16'd0);
    end
    wait_to(32);
    latch_q = 1'b0;

    // Clear counter before the saturation run.
    wait_to(41);
    cnt_clr = 1'b1;
    push(42, "clr_start", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0);
    wait_to(42);
    cnt_clr = 1'b0;

    // Nine clean pulses: count saturates at 7 on the seventh rise.
    for (int i = 0; i < 9; i++) begin
      int base;
      logic [2:0] c;
      logic sat;
      base = 44 + 16 * i;
      c = (i + 1 >= 7) ? 3'd7 : 3'(i + 1);
      sat = (i + 1 >= 7);
      wait_to(base);
      latch_q = 1'b1;
      push(base + 6, "sat_rise", 1'b1, 1'b1, 1'b0, c, sat, 1'b0, 16'd0);
      wait_to(base + 8);
      latch_q = 1'b0;
      push(base + 14, "sat_fall", 1'b0, 1'b0, 1'b1, c, sat, 1'b0, 16'd0);
    end

    // cnt_clr on the same edge as a rise leaves a count of one.
    wait_to(195);
    latch_q = 1'b1;
    push(200, "simul_pre", 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 16'd0);
    wait_to(200);
    cnt_clr = 1'b1;
    push(201, "simul_clr_rise", 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 16'd0);
    push(202, "simul_post", 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 16'd0);
    wait_to(201);
    cnt_clr = 1'b0;

    // Plain cnt_clr.
    wait_to(205);
    cnt_clr = 1'b1;
    push(206, "clr_only", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0);
    wait_to(206);
    cnt_clr = 1'b0;

    // Mid-operation reset with latch_q still high.
    wait_to(210);
    clear_n = 1'b0;
    #1;
    total++;
    assert ({level, rise, fall, event_cnt, cnt_sat} === 7'b0)
    else begin
      bad++;
      $error("FAIL async_clear got lvl/rise/fall/cnt/sat=%b/%b/%b/%0d/%b expected all 0",
             level, rise, fall, event_cnt, cnt_sat);
    end
`ifdef LATCH_MON_TS_EN
    total++;
    assert (rise_ts === 16'd0)
    else begin
      bad++;
      $error("FAIL async_clear_ts got rise_ts=%0d expected 0", rise_ts);
    end
`endif
    wait_to(212);
    clear_n = 1'b1;
    push(217, "rerise_pre", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0);
    push(218, "rerise", 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 16'd5);
    push(219, "rerise_post", 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 16'd5);

    wait_to(225);
    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL drain got %0d pending checks expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got no completion expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
